// File: rtl/r2fft_pkg.sv
// Shared types and helpers for the radix-2 FFT output path: FSM state encoding,
// complex sample layout and the address bit-reversal used to undo in-place ordering.
package r2fft_pkg;

    localparam int SAMPLE_DW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [SAMPLE_DW-1:0] re;
        logic [SAMPLE_DW-1:0] im;
    } sample_t;

    // Reverses the low 'width' bits of v; bits at and above 'width' come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r = r | (((v >> i) & 32'd1) << (width - 1 - i));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/r2fft_skid_fifo.sv
// Two-entry FIFO for {index, data} words; a push into an empty FIFO falls through to the head.
// Latency: 0 cycles push-to-head when empty, otherwise in order behind the stored entries.
// Backpressure: pop is taken only while head_vld; the producer must never push into a full FIFO.
module r2fft_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [1:0]   count,
    output logic         head_vld,
    output logic [W-1:0] head_dat
);

    logic [W-1:0] mem0;
    logic [W-1:0] mem1;

    assign head_vld = (count != 2'd0) || push;

    always_comb begin
        head_dat = '0;
        if (count != 2'd0) begin
            head_dat = mem0;
        end else if (push) begin
            head_dat = push_dat;
        end
    end

    // A push popped in the same cycle while empty is consumed straight through and never stored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 2'd0;
            mem0  <= '0;
            mem1  <= '0;
        end else begin
            if (pop && (count != 2'd0)) begin
                if (count == 2'd2) begin
                    mem0 <= mem1;
                    if (push) begin
                        mem1 <= push_dat;
                    end
                end else if (push) begin
                    mem0 <= push_dat;
                end
                count <= count - 2'd1 + {1'b0, push};
            end else if (push && !pop) begin
                if (count == 2'd0) begin
                    mem0 <= push_dat;
                end else begin
                    mem1 <= push_dat;
                end
                count <= count + 2'd1;
            end
        end
    end

endmodule

// File: rtl/r2fft_output_unloader.sv
// Streams a finished FFT frame out of the result RAM in natural order; R2FFT_UNLOAD_BITREV_EN selects bit-reversed RAM addressing.
// Latency: first read the cycle after start, first beat one cycle later; N+2 cycles start-to-done at full rate.
// Backpressure: reads are credit-limited to the 2-entry skid FIFO, counting the read still in flight.
module r2fft_output_unloader
    import r2fft_pkg::*;
#(
    parameter int BIT_WIDTH  = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    ram_rd_en,
    output logic [BIT_WIDTH-1:0]    ram_rd_addr,
    input  logic [2*DATA_WIDTH-1:0] ram_rd_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [2*DATA_WIDTH-1:0] m_data,
    output logic [BIT_WIDTH-1:0]    m_index,
    output logic                    m_last,
    output logic                    done
);

    localparam int EW = BIT_WIDTH + 2*DATA_WIDTH;
    localparam logic [BIT_WIDTH-1:0] LAST_IDX = '1;

    state_t               state;
    logic [BIT_WIDTH-1:0] rd_cnt;
    logic [BIT_WIDTH-1:0] rd_addr;
    logic [BIT_WIDTH-1:0] inflight_idx;
    logic                 inflight;
    logic                 rd_fire;
    logic                 hs;
    logic                 last_hs;
    logic [1:0]           fifo_count;
    logic                 head_vld;
    logic [EW-1:0]        head;

    // Credit covers both stored entries and the read whose data returns next cycle.
    assign rd_fire = (state == RUN) && ((fifo_count + {1'b0, inflight}) < 2'd2);

`ifdef R2FFT_UNLOAD_BITREV_EN
    assign rd_addr = BIT_WIDTH'(bitrev(32'(rd_cnt), BIT_WIDTH));
`else
    assign rd_addr = rd_cnt;
`endif

    assign ram_rd_en   = rd_fire;
    assign ram_rd_addr = rd_fire ? rd_addr : '0;

    r2fft_skid_fifo #(
        .W (EW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_dat ({inflight_idx, ram_rd_data}),
        .pop      (hs),
        .count    (fifo_count),
        .head_vld (head_vld),
        .head_dat (head)
    );

    assign m_valid            = head_vld;
    assign {m_index, m_data}  = head;
    assign m_last             = head_vld && (m_index == LAST_IDX);
    assign hs                 = m_valid && m_ready;
    assign last_hs            = hs && m_last;
    assign busy               = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rd_cnt       <= '0;
            inflight     <= 1'b0;
            inflight_idx <= '0;
            done         <= 1'b0;
        end else begin
            inflight     <= rd_fire;
            inflight_idx <= rd_cnt;
            done         <= last_hs && (state == DRAIN);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        rd_cnt <= '0;
                    end
                end
                RUN: begin
                    // The counter parks at N-1 so it never wraps inside a frame.
                    if (rd_fire) begin
                        if (rd_cnt == LAST_IDX) begin
                            state <= DRAIN;
                        end else begin
                            rd_cnt <= rd_cnt + BIT_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (last_hs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_r2fft_output_unloader.sv
// Directed-plus-random bench for r2fft_output_unloader with N=16 and a RAM whose data equals its address.
module tb_r2fft_output_unloader;
    import r2fft_pkg::*;

    localparam int BW = 4;
    localparam int DW = 16;
    localparam int N  = 1 << BW;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            busy;
    logic            ram_rd_en;
    logic [BW-1:0]   ram_rd_addr;
    logic [2*DW-1:0] ram_rd_data;
    logic            m_valid;
    logic            m_ready;
    logic [2*DW-1:0] m_data;
    logic [BW-1:0]   m_index;
    logic            m_last;
    logic            done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_edge = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Registered RAM: data equals the address read; garbage when not read.
    always @(posedge clk) ram_rd_data <= ram_rd_en ? (2*DW)'(ram_rd_addr) : $urandom;

    r2fft_output_unloader #(
        .BIT_WIDTH  (BW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_index     (m_index),
        .m_last      (m_last),
        .done        (done)
    );

    // RAM address holding natural-order sample i.
    function automatic int exp_addr(input int i);
`ifdef R2FFT_UNLOAD_BITREV_EN
        int x;
        int r;
        x = i;
        r = 0;
        for (int b = 0; b < BW; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
`else
        return i;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_rd_en", ram_rd_en, 0);
            chk("idle_addr", ram_rd_addr, 0);
            chk("idle_valid", m_valid, 0);
        end
    endtask

    // rmode: 0 ready always, 1 stall-then-toggle pattern, 2 random ready.
    task automatic run_frame(input int rmode, input int busy_beat, input int rst_beat,
                             input bit prestarted, input bit chain);
        int beats = 0;
        int issued = 0;
        int bp = 0;
        int rel;
        bit fin = 0;
        bit done_exp = 0;
        bit busy_sent = 0;
        bit stalled = 0;
        bit hs;
        logic [2*DW-1:0] held_dat = '0;
        sample_t smp;
        if (!prestarted) begin
            @(negedge clk);
            start = 1'b1;
            start_edge = cyc + 1;
        end
        for (int t = 0; t < 300 && !fin; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (beats == rst_beat) begin
                rst = 1'b0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_rd_en", ram_rd_en, 0);
                chk("rst_addr", ram_rd_addr, 0);
                chk("rst_valid", m_valid, 0);
                chk("rst_data", m_data, 0);
                chk("rst_index", m_index, 0);
                chk("rst_last", m_last, 0);
                chk("rst_done", done, 0);
                @(negedge clk);
                rst = 1'b1;
                fin = 1;
            end else begin
                case (rmode)
                    0: m_ready = 1'b1;
                    1: begin
                        if (beats < 3) begin
                            m_ready = 1'b1;
                        end else begin
                            m_ready = (bp >= 5) && (((bp - 5) % 2) == 0);
                            bp++;
                        end
                    end
                    default: m_ready = ($urandom_range(0, 3) != 0);
                endcase
                if (beats == busy_beat && !busy_sent) begin
                    start = 1'b1;
                    busy_sent = 1;
                end
                #1;
                rel = cyc - start_edge;
                chk("busy", busy, beats < N);
                chk("done", done, done_exp);
                if (done_exp) begin
                    chk("valid_end", m_valid, 0);
                    // Done is sampled by the (N+2)th rising edge after the start edge.
                    if (rmode == 0) chk("done_time", rel, N + 1);
                    fin = 1;
                    if (chain) begin
                        start = 1'b1;
                        start_edge = cyc + 1;
                    end
                end else begin
                    chk("rd_en", ram_rd_en, (issued < N) && ((issued - beats) < 2));
                    chk("rd_addr", ram_rd_addr, ram_rd_en ? exp_addr(issued) : 0);
                    chk("valid", m_valid, issued > beats);
                    if (m_valid) begin
                        smp = m_data;
                        chk("index", m_index, beats);
                        chk("data_re", smp.re, 0);
                        chk("data_im", smp.im, exp_addr(beats));
                        chk("last", m_last, beats == N - 1);
                        if (stalled) chk("hold", m_data, held_dat);
                    end else begin
                        chk("last_idle", m_last, 0);
                    end
                    hs = m_valid && m_ready;
                    if (hs && rmode == 0) chk("beat_time", rel, beats + 1);
                    stalled  = m_valid && !m_ready;
                    held_dat = m_data;
                    if (ram_rd_en) issued++;
                    if (hs) begin
                        beats++;
                        if (beats == N) done_exp = 1;
                    end
                end
            end
        end
        if (!fin) chk("timeout", 0, 1);
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        m_ready = 1'b0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_rd_en", ram_rd_en, 0);
        chk("reset_addr", ram_rd_addr, 0);
        chk("reset_valid", m_valid, 0);
        chk("reset_data", m_data, 0);
        chk("reset_index", m_index, 0);
        chk("reset_last", m_last, 0);
        chk("reset_done", done, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(2);

        run_frame(0, -1, -1, 1'b0, 1'b0);
        idle(2);
        run_frame(1, -1, -1, 1'b0, 1'b0);
        idle(1);
        run_frame(2, 6, -1, 1'b0, 1'b0);
        idle(2);
        run_frame(2, -1, 7, 1'b0, 1'b0);
        idle(3);
        run_frame(2, -1, -1, 1'b0, 1'b0);
        idle(1);
        run_frame(0, -1, -1, 1'b0, 1'b1);
        run_frame(0, -1, -1, 1'b1, 1'b0);
        idle(1);
        for (int k = 0; k < 4; k++) begin
            run_frame(2, -1, -1, 1'b0, 1'b0);
            idle($urandom_range(1, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/r2fft_output_unloader.md
Name: r2fft_output_unloader

Overview:
Drains a completed FFT frame from the result RAM and streams it out as a valid/ready stream in natural frequency order. The FFT core's in-place result is stored bit-reversed, so this block reads RAM address bitrev(i) for output index i. It sits downstream of the butterfly core and result buffer, and upstream of the system output interface. It absorbs the 1-cycle RAM read latency with a 2-entry skid FIFO, so a full frame streams at 1 sample/cycle under no backpressure.

Parameters:
BIT_WIDTH, 10, log2 of FFT length N; the frame has N = 2**BIT_WIDTH samples.
DATA_WIDTH, 16, width of each real/imag component; a sample is 2*DATA_WIDTH bits, {re, im}.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  1-cycle pulse from the FFT core: frame ready in RAM
busy  out  1  high from start acceptance until the final output handshake
ram_rd_en  out  1  RAM read strobe
ram_rd_addr  out  BIT_WIDTH  RAM read address
ram_rd_data  in  2*DATA_WIDTH  RAM read data, valid exactly 1 cycle after ram_rd_en
m_valid  out  1  output sample valid
m_ready  in  1  downstream ready
m_data  out  2*DATA_WIDTH  output sample
m_index  out  BIT_WIDTH  natural-order index of m_data
m_last  out  1  high with the sample at index N-1
done  out  1  1-cycle pulse after the frame's last handshake

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0, FIFO empty. busy, ram_rd_en, m_valid, m_last and done are 0. ram_rd_addr, m_data and m_index are 0.
- The FSM has three states: IDLE, RUN and DRAIN.
- IDLE: start=1 moves to RUN and clears the read counter. busy goes high on the next cycle.
- In any state other than IDLE, start is ignored.
- RUN: ram_rd_en = (fifo_count + inflight) < 2, where inflight is the read issued in the previous cycle.
  - ram_rd_addr = bitrev(count).
  - The counter increments on each issued read.
  - The read at count = N-1 moves the FSM to DRAIN. The counter does not wrap within a frame.
- RAM data is captured into the FIFO one cycle after ram_rd_en, together with its natural index.
- Output: m_valid = FIFO not empty. m_data and m_index come from the FIFO head. m_last = (m_index == N-1).
- A handshake is m_valid & m_ready, and pops the head.
- While m_valid=1 and m_ready=0, m_data, m_index and m_last are held stable.
- A FIFO push and pop may occur in the same cycle. The FIFO never overflows, because credit includes the in-flight read.
- DRAIN: no reads are issued. When the handshake with m_last=1 occurs, the FSM returns to IDLE, busy drops, and done pulses in the following cycle.
- A start arriving in the done cycle is accepted.
- Latency: start at edge k gives ram_rd_en in cycle k+1 and the first m_valid in cycle k+2. With m_ready held high, the N beats are contiguous, and the frame takes N+2 cycles from start to done.
- An async reset mid-frame aborts the frame immediately. No done pulse is issued, and the next start restarts at index 0.
- ram_rd_addr is 0 whenever ram_rd_en=0.

Optional Feature:
R2FFT_UNLOAD_BITREV_EN
- Defined: ram_rd_addr = bitrev(count), for cores that store their output bit-reversed. This is the default build.
- Undefined: ram_rd_addr = count (natural order), for cores that reorder internally.
- All handshake and timing behaviour is identical in both builds.

Decomposition:
- Package r2fft_pkg holds:
  - the state typedef enum {IDLE, RUN, DRAIN};
  - a bitrev function parameterised by width;
  - the sample typedef struct {re, im} built on DATA_WIDTH.
- Sub-module r2fft_skid_fifo: 2-entry FIFO with push, pop, count and head outputs, carrying {index, data}, with async active-low reset.
- The counter is inline in the unloader.

Test Plan:
All scenarios use BIT_WIDTH=4 (N=16) and a RAM model returning data = address.
- Free-running frame: start, m_ready=1 -> 16 contiguous beats, m_data = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; m_index = 0..15; m_last only on the 16th beat; done 1 cycle later; 18 cycles from start to done.
- Backpressure: m_ready low for 5 cycles after beat 3, then toggling 1010 -> no lost or duplicated beats; at most 2 samples held plus in-flight; outputs stable while stalled; ram_rd_en deasserts while the FIFO is full.
- Start while busy: second start pulse at beat 6 -> ignored; exactly 16 beats and one done pulse.
- Reset mid-frame: rst low at beat 7 -> all outputs 0 asynchronously, no done; after release, start -> a full frame from index 0.
- Back-to-back: start asserted in the done cycle -> second frame accepted, first beat 2 cycles later, data identical to the first frame.
- R2FFT_UNLOAD_BITREV_EN undefined -> m_data = 0..15 in order, same timing as the free-running case.
